// File: rtl/axi_araddr_gen.sv
// Frame-region read address generator: splits a 2-D region (lines of h_beats
// beats) into AXI bursts that never cross 4 KB and pushes them into an address FIFO.
module axi_araddr_gen #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_BYTES = 32,
  parameter int unsigned MAX_BURST  = 16,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic                  i_abort,
  input  logic [ADDR_WIDTH-1:0] i_base_addr,
  input  logic [ADDR_WIDTH-1:0] i_line_stride,
  input  logic [CNT_WIDTH-1:0]  i_h_beats,
  input  logic [CNT_WIDTH-1:0]  i_v_lines,
  output logic [ADDR_WIDTH+7:0] o_wr_data,
  output logic                  o_wr_en,
  input  logic                  i_wr_vld,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam int unsigned OFFS = $clog2(DATA_BYTES);
  localparam int unsigned BW   = (CNT_WIDTH > 13) ? CNT_WIDTH : 13;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DONE} state_t;

  state_t                r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_cur_addr, r_line_addr, r_stride;
  logic [CNT_WIDTH-1:0]  r_h_beats, r_rem, r_lines_left;
  logic [8:0]            r_burst;

  logic [ADDR_WIDTH-1:0] w_cur_nxt, w_line_nxt, w_stride_nxt, w_step, w_next_line;
  logic [CNT_WIDTH-1:0]  w_h_nxt, w_rem_nxt, w_lines_nxt;
  logic [8:0]            w_burst_nxt;
  logic [BW-1:0]         w_b4k, w_bmin;
  logic                  w_push, w_more, w_last_line;
  logic [ADDR_WIDTH+7:0] w_wr_data_nxt;
  logic                  w_wr_en_nxt, w_busy_nxt, w_done_nxt;

  assign w_push      = (r_state == S_ISSUE) && i_wr_vld;
  assign w_more      = BW'(r_rem) > BW'(r_burst);
  assign w_last_line = r_lines_left <= CNT_WIDTH'(1);
  assign w_step      = ADDR_WIDTH'(r_burst) << OFFS;
  assign w_next_line = r_line_addr + r_stride;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic; abort overrides everything but reset
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:
        if (i_start)
          w_state_nxt = (i_h_beats != '0 && i_v_lines != '0) ? S_ISSUE : S_DONE;
      S_ISSUE:
        if (w_push && !w_more && w_last_line) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (i_abort) w_state_nxt = S_IDLE;
  end

  // Datapath next values: load on start, advance within a line, or step to next line
  always_comb begin
    w_cur_nxt    = r_cur_addr;
    w_line_nxt   = r_line_addr;
    w_stride_nxt = r_stride;
    w_h_nxt      = r_h_beats;
    w_rem_nxt    = r_rem;
    w_lines_nxt  = r_lines_left;
    if (r_state == S_IDLE && i_start) begin
      w_cur_nxt    = i_base_addr;
      w_line_nxt   = i_base_addr;
      w_stride_nxt = i_line_stride;
      w_h_nxt      = i_h_beats;
      w_rem_nxt    = i_h_beats;
      w_lines_nxt  = i_v_lines;
    end else if (w_push) begin
      if (w_more) begin
        w_cur_nxt = r_cur_addr + w_step;
        w_rem_nxt = CNT_WIDTH'(r_rem - CNT_WIDTH'(r_burst));
      end else if (!w_last_line) begin
        w_cur_nxt   = w_next_line;
        w_line_nxt  = w_next_line;
        w_rem_nxt   = r_h_beats;
        w_lines_nxt = r_lines_left - CNT_WIDTH'(1);
      end
    end
  end

  // Burst for the next descriptor, precomputed so outputs can be registered
  always_comb begin
    w_b4k = BW'((13'h1000 - {1'b0, w_cur_nxt[11:0]}) >> OFFS);
    w_bmin = BW'(w_rem_nxt);
    if (w_bmin > BW'(MAX_BURST)) w_bmin = BW'(MAX_BURST);
    if (w_bmin > w_b4k)          w_bmin = w_b4k;
    w_burst_nxt = 9'(w_bmin);
  end

  // Output logic
  always_comb begin
    w_wr_en_nxt   = (w_state_nxt == S_ISSUE);
    w_busy_nxt    = (w_state_nxt != S_IDLE);
    w_done_nxt    = (w_state_nxt == S_DONE);
    w_wr_data_nxt = '0;
    if (w_wr_en_nxt) w_wr_data_nxt = {w_cur_nxt, 8'(w_burst_nxt - 9'd1)};
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cur_addr   <= '0;
      r_line_addr  <= '0;
      r_stride     <= '0;
      r_h_beats    <= '0;
      r_rem        <= '0;
      r_lines_left <= '0;
      r_burst      <= '0;
      o_wr_data    <= '0;
      o_wr_en      <= 1'b0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
    end else begin
      r_cur_addr   <= w_cur_nxt;
      r_line_addr  <= w_line_nxt;
      r_stride     <= w_stride_nxt;
      r_h_beats    <= w_h_nxt;
      r_rem        <= w_rem_nxt;
      r_lines_left <= w_lines_nxt;
      r_burst      <= w_burst_nxt;
      o_wr_data    <= w_wr_data_nxt;
      o_wr_en      <= w_wr_en_nxt;
      o_busy       <= w_busy_nxt;
      o_done       <= w_done_nxt;
    end
  end

endmodule

// File: tb/tb_axi_araddr_gen.sv
// Scoreboard bench for axi_araddr_gen: stimulus queues expected descriptors and
// done pulses with their cycle numbers; a negedge monitor pops and compares.
module tb_axi_araddr_gen;

  logic        clk = 1'b0;
  logic        rst, start, abort, wr_vld;
  logic [31:0] base_addr, line_stride;
  logic [15:0] h_beats, v_lines;
  logic [39:0] wr_data;
  logic        wr_en, busy, done;

  typedef struct {
    bit          is_done;
    logic [31:0] addr;
    logic [7:0]  len;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_total = 0;
  int   n_pass = 0;

  axi_araddr_gen #(.ADDR_WIDTH(32), .DATA_BYTES(32), .MAX_BURST(16), .CNT_WIDTH(16)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_abort(abort),
    .i_base_addr(base_addr), .i_line_stride(line_stride),
    .i_h_beats(h_beats), .i_v_lines(v_lines),
    .o_wr_data(wr_data), .o_wr_en(wr_en), .i_wr_vld(wr_vld),
    .o_busy(busy), .o_done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic exp_push(input logic [31:0] a, input logic [7:0] l, input int c);
    exp_t e;
    e.is_done = 1'b0; e.addr = a; e.len = l; e.cyc = c;
    exp_q.push_back(e);
  endtask

  task automatic exp_done(input int c);
    exp_t e;
    e.is_done = 1'b1; e.addr = '0; e.len = '0; e.cyc = c;
    exp_q.push_back(e);
  endtask

  // Monitor: every accepted push or done pulse must match the queue head
  always @(negedge clk) begin
    if (!rst && ((wr_en && wr_vld) || done)) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_output: got wr_en=%b done=%b data=%h expected nothing (cycle %0d)",
                 wr_en, done, wr_data, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("kind_is_done", 64'(done), 64'(e.is_done));
        chk("event_cycle", 64'(cyc), 64'(e.cyc));
        if (!e.is_done) chk("descriptor", 64'(wr_data), 64'({e.addr, e.len}));
      end
    end
  end

  // Start pulse in cycle n; returns one cycle later (cycle n+1, before its negedge)
  task automatic drive_start(input logic [31:0] b, input logic [31:0] s,
                             input logic [15:0] h, input logic [15:0] v, output int n);
    @(posedge clk); #1;
    base_addr = b; line_stride = s; h_beats = h; v_lines = v; start = 1'b1;
    n = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_drain(input int max_cyc);
    for (int i = 0; i < max_cyc && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_total++;
      $display("FAIL drain_timeout: got %0d pending events expected 0", exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic basic_region();
    int n;
    drive_start(32'h1000, 32'h0, 16'd40, 16'd1, n);
    exp_push(32'h1000, 8'd15, n + 1);
    exp_push(32'h1200, 8'd15, n + 2);
    exp_push(32'h1400, 8'd7,  n + 3);
    exp_done(n + 4);
    wait_drain(20);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; abort = 1'b0; wr_vld = 1'b1;
    base_addr = '0; line_stride = '0; h_beats = '0; v_lines = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_wr_en", 64'(wr_en), 64'd0);
    chk("reset_wr_data", 64'(wr_data), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Basic split into 16/16/8 beats
    basic_region();
    @(negedge clk);
    chk("idle_busy_after_done", 64'(busy), 64'd0);

    // 4 KB boundary split
    drive_start(32'h0F80, 32'h0, 16'd8, 16'd1, n);
    exp_push(32'h0F80, 8'd3, n + 1);
    exp_push(32'h1000, 8'd3, n + 2);
    exp_done(n + 3);
    wait_drain(20);

    // Multi-line without bubbles; a start mid-region must be ignored
    drive_start(32'h0, 32'h2000, 16'd16, 16'd3, n);
    exp_push(32'h0000, 8'd15, n + 1);
    exp_push(32'h2000, 8'd15, n + 2);
    exp_push(32'h4000, 8'd15, n + 3);
    exp_done(n + 4);
    @(posedge clk); #1;
    base_addr = 32'h8000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_drain(20);

    // Backpressure: stall five cycles after the first push
    drive_start(32'h1000, 32'h0, 16'd40, 16'd1, n);
    exp_push(32'h1000, 8'd15, n + 1);
    exp_push(32'h1200, 8'd15, n + 7);
    exp_push(32'h1400, 8'd7,  n + 8);
    exp_done(n + 9);
    @(posedge clk); #1 wr_vld = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall_wr_en", 64'(wr_en), 64'd1);
      chk("stall_wr_data", 64'(wr_data), 64'({32'h1200, 8'd15}));
      @(posedge clk); #1;
    end
    wr_vld = 1'b1;
    wait_drain(20);

    // Zero-size regions
    drive_start(32'h100, 32'h0, 16'd0, 16'd5, n);
    exp_done(n + 1);
    @(negedge clk);
    chk("zero_busy_n1", 64'(busy), 64'd1);
    @(posedge clk);
    @(negedge clk);
    chk("zero_busy_n2", 64'(busy), 64'd0);
    wait_drain(5);
    drive_start(32'h100, 32'h0, 16'd4, 16'd0, n);
    exp_done(n + 1);
    wait_drain(5);

    // Abort coinciding with the second push: push still counts, no done
    drive_start(32'h1000, 32'h0, 16'd40, 16'd1, n);
    exp_push(32'h1000, 8'd15, n + 1);
    exp_push(32'h1200, 8'd15, n + 2);
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    chk("abort_wr_en", 64'(wr_en), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    wait_drain(5);
    repeat (3) @(posedge clk);
    basic_region();

    // Reset mid-region discards the rest
    drive_start(32'h1000, 32'h0, 16'd40, 16'd1, n);
    exp_push(32'h1000, 8'd15, n + 1);
    @(posedge clk); #1 begin rst = 1'b1; wr_vld = 1'b0; end
    @(posedge clk); #1 begin rst = 1'b0; wr_vld = 1'b1; end
    @(negedge clk);
    chk("rst_mid_wr_en", 64'(wr_en), 64'd0);
    chk("rst_mid_wr_data", 64'(wr_data), 64'd0);
    chk("rst_mid_busy", 64'(busy), 64'd0);
    wait_drain(5);
    repeat (3) @(posedge clk);
    basic_region();

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/axi_araddr_gen.md
AXI_ARADDR_GEN -- requirements
Module: axi_araddr_gen

Interface
REQ-001 Parameter ADDR_WIDTH, default 32: AXI byte-address width.
REQ-002 Parameter DATA_BYTES, default 32: bytes per AXI beat; power of two, 4..256.
REQ-003 Parameter MAX_BURST, default 16: maximum beats per burst; 1..256.
REQ-004 Parameter CNT_WIDTH, default 16: width of the h_beats and v_lines counters.
REQ-005 clk  in  1: single clock; every register updates on its rising edge.
REQ-006 rst  in  1: reset, synchronous, active-high.
REQ-007 start  in  1: one-cycle request pulse to begin a frame-region read.
REQ-008 abort  in  1: synchronous abort of the current region.
REQ-009 base_addr  in  ADDR_WIDTH: first-line start address; DATA_BYTES-aligned.
REQ-010 line_stride  in  ADDR_WIDTH: byte offset between consecutive line starts; DATA_BYTES-aligned.
REQ-011 h_beats  in  CNT_WIDTH: beats per line.
REQ-012 v_lines  in  CNT_WIDTH: number of lines.
REQ-013 wr_data  out  ADDR_WIDTH+8: burst descriptor {addr[ADDR_WIDTH-1:0], len[7:0]}, with len = beats-1; connects to the address-FIFO write port.
REQ-014 wr_en  out  1: descriptor valid.
REQ-015 wr_vld  in  1: address FIFO not full.
REQ-016 busy  out  1: region in progress.
REQ-017 done  out  1: one-cycle pulse when a region completes normally.

Function
REQ-018 The block SHALL implement three states: IDLE, ISSUE and DONE.
REQ-019 In IDLE, start SHALL latch base_addr, line_stride, h_beats and v_lines into internal registers; the inputs are not sampled again until the next IDLE.
REQ-020 On start, the next state SHALL be ISSUE when h_beats!=0 and v_lines!=0; otherwise it SHALL be DONE.
REQ-021 On start, cur_addr and line_addr SHALL load base_addr, rem SHALL load h_beats, and lines_left SHALL load v_lines.
REQ-022 In ISSUE, burst SHALL equal min(rem, MAX_BURST, beats_to_4k), where beats_to_4k = (4096 - cur_addr[11:0]) / DATA_BYTES.
REQ-023 A burst SHALL never cross a 4 KB boundary.
REQ-024 In ISSUE, wr_en SHALL be 1 and wr_data SHALL equal {cur_addr, burst-1}.
REQ-025 In any other state, wr_en SHALL be 0 and wr_data SHALL be all zeros.
REQ-026 A push occurs when wr_en=1 and wr_vld=1.
REQ-027 While wr_vld=0, wr_en SHALL remain 1 and wr_data SHALL remain stable; no descriptor is dropped or duplicated.
REQ-028 On a push with rem>burst: cur_addr SHALL advance by burst*DATA_BYTES, rem SHALL decrease by burst, and the state SHALL stay ISSUE.
REQ-029 On a push with rem==burst and lines_left>1: line_addr and cur_addr SHALL load line_addr+line_stride, rem SHALL load h_beats, lines_left SHALL decrement, and the state SHALL stay ISSUE.
REQ-030 Pushes SHALL sustain one per cycle across line boundaries, with no bubble.
REQ-031 On a push with rem==burst and lines_left==1, the next state SHALL be DONE.
REQ-032 Address arithmetic SHALL be modulo 2^ADDR_WIDTH; wrap-around is not flagged.
REQ-033 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-034 busy SHALL be 1 in ISSUE and DONE, and 0 in IDLE.
REQ-035 start SHALL be ignored when the state is not IDLE.
REQ-036 Latency: with wr_vld=1, start in cycle N SHALL produce the first wr_en in cycle N+1.
REQ-037 Latency: done SHALL pulse in the cycle after the final push.
REQ-038 abort in any state SHALL force IDLE on the next edge, with wr_en=0 and no done pulse.
REQ-039 abort SHALL take priority over start and over a push in the same cycle; a push coinciding with abort SHALL still count as accepted by the FIFO.

Reset
REQ-040 While rst=1, at the next clk edge the state SHALL be IDLE.
REQ-041 Reset SHALL clear all internal registers to 0.
REQ-042 Reset SHALL drive wr_en=0, wr_data=0, busy=0 and done=0.
REQ-043 Reset mid-region SHALL discard the region with no further pushes; reset has priority over abort and start.

Verification (DATA_BYTES=32, MAX_BURST=16)
REQ-044 Basic burst split: base 0x1000, h_beats 40, v_lines 1, wr_vld=1 -> pushes (0x1000,15), (0x1200,15), (0x1400,7) in cycles N+1..N+3, then done in N+4.
REQ-045 4 KB boundary: base 0x0F80, h_beats 8, v_lines 1 -> pushes (0x0F80,3), (0x1000,3).
REQ-046 Multi-line: base 0, stride 0x2000, h_beats 16, v_lines 3 -> pushes (0x0000,15), (0x2000,15), (0x4000,15) in consecutive cycles, then done.
REQ-047 Backpressure: the REQ-044 stimulus with wr_vld=0 for 5 cycles after the first push -> wr_en held at 1, wr_data held at (0x1200,15), exactly 3 pushes total.
REQ-048 Zero size: h_beats=0 -> no push; busy=1 and done=1 in N+1; IDLE in N+2.
REQ-049 Abort/reset: abort or rst asserted after the first push of REQ-044 -> wr_en=0 next cycle, no done, and a new start is accepted correctly.
